// File: rtl/vram_arbiter.sv
// Video RAM arbiter: video character fetches own the RAM port with zero wait,
// CPU req/ack accesses fill the remaining idle slots.
module vram_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int STALL_WIDTH = 8
) (
  input  logic                   clk_pixel,
  input  logic                   clk_locked,
  input  logic [ADDR_WIDTH-1:0]  vid_addr,
  input  logic                   vid_en,
  output logic [DATA_WIDTH-1:0]  vid_data,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  output logic                   cpu_ack,
  output logic [STALL_WIDTH-1:0] stall_cnt,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   cpu_grant_s;
  logic                   we_q, we_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic [DATA_WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic                   vid_prev_q, vid_prev_d;
  logic [DATA_WIDTH-1:0]  vid_hold_q, vid_hold_d;
  logic [STALL_WIDTH-1:0] stall_q, stall_d;

  assign cpu_grant_s = (state_q == ST_IDLE) && cpu_req && !vid_en;

  // RAM port mux: video always wins, CPU only when granted.
  always_comb begin
    ram_addr  = {ADDR_WIDTH{1'b0}};
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = {DATA_WIDTH{1'b0}};
    if (vid_en) begin
      ram_addr = vid_addr;
      ram_en   = 1'b1;
    end else if (cpu_grant_s) begin
      ram_addr  = cpu_addr;
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else begin
      ram_en = 1'b0;
    end
  end

  // CPU FSM next state, captured write flag and read data.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_grant_s) begin
          state_d = ST_RESP;
          we_d    = cpu_we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        state_d = ST_ACK;
        // we_q is latched at grant so a protocol-violating CPU cannot alter it.
        if (!we_q) begin
          cpu_rdata_d = ram_rdata;
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cpu_ack_d = (state_d == ST_ACK);
  end

  // Video hold register and saturating stall counter next state.
  always_comb begin
    vid_prev_d = vid_en;
    if (vid_prev_q) begin
      vid_hold_d = ram_rdata;
    end else begin
      vid_hold_d = vid_hold_q;
    end
    if ((state_q == ST_IDLE) && cpu_req && vid_en && (stall_q != {STALL_WIDTH{1'b1}})) begin
      stall_d = stall_q + {{(STALL_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pixel or negedge clk_locked) begin
    if (!clk_locked) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= {DATA_WIDTH{1'b0}};
      vid_prev_q  <= 1'b0;
      vid_hold_q  <= {DATA_WIDTH{1'b0}};
      stall_q     <= {STALL_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_prev_q  <= vid_prev_d;
      vid_hold_q  <= vid_hold_d;
      stall_q     <= stall_d;
    end
  end

  assign vid_data  = vid_prev_q ? ram_rdata : vid_hold_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM model.
module tb_vram_arbiter;

  logic        clk_pixel = 1'b0;
  logic        clk_locked;
  logic [15:0] vid_addr;
  logic        vid_en;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [7:0]  stall_cnt;
  logic [15:0] ram_addr;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  logic [15:0] vid_addr2;
  logic        vid_en2;
  logic [7:0]  vid_data2;
  logic        cpu_req2;
  logic [7:0]  cpu_rdata2;
  logic        cpu_ack2;
  logic [1:0]  stall_cnt2;
  logic [15:0] ram_addr2;
  logic        ram_en2;
  logic        ram_we2;
  logic [7:0]  ram_wdata2;
  logic [7:0]  ram_rdata2;

  logic [7:0] mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_pixel = ~clk_pixel;

  vram_arbiter dut (
    .clk_pixel(clk_pixel), .clk_locked(clk_locked),
    .vid_addr(vid_addr), .vid_en(vid_en), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .stall_cnt(stall_cnt), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STALL_WIDTH(2)) dut_sat (
    .clk_pixel(clk_pixel), .clk_locked(clk_locked),
    .vid_addr(vid_addr2), .vid_en(vid_en2), .vid_data(vid_data2),
    .cpu_req(cpu_req2), .cpu_we(1'b0), .cpu_addr(16'h0000),
    .cpu_wdata(8'h00), .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2),
    .stall_cnt(stall_cnt2), .ram_addr(ram_addr2), .ram_en(ram_en2),
    .ram_we(ram_we2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
  );

  // Single-port synchronous RAM: write commits at the edge, read data one cycle later.
  always @(posedge clk_pixel) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  initial begin
    logic [7:0] exp_hold;
    logic       prev_vid;
    logic [7:0] prev_data;
    int         acks;

    for (int i = 0; i < 1000; i += 8) mem[16'h8000 + 16'(i)] = 8'(i * 7 + 3);
    mem[16'hF600] = 8'h41;
    mem[16'h0010] = 8'h99;
    mem[16'h0020] = 8'h77;
    clk_locked = 1'b0;
    vid_en = 1'b0; vid_addr = 16'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    vid_en2 = 1'b0; vid_addr2 = 16'h0000; cpu_req2 = 1'b0; ram_rdata2 = 8'h00;

    // Reset values
    tick(); tick();
    check_eq("rst_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_rdata", 32'(cpu_rdata), 32'h0);
    check_eq("rst_vid_data", 32'(vid_data), 32'h0);
    check_eq("rst_stall", 32'(stall_cnt), 32'h0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    #2 clk_locked = 1'b1;
    tick();

    // Single read of 0xF600
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF600;
    #1;
    check_eq("rd_ram_en_c0", 32'(ram_en), 32'd1);
    check_eq("rd_ram_addr_c0", 32'(ram_addr), 32'hF600);
    check_eq("rd_ram_we_c0", 32'(ram_we), 32'd0);
    tick();
    check_eq("rd_ack_c1", 32'(cpu_ack), 32'd0);
    check_eq("rd_ram_en_c1", 32'(ram_en), 32'd0);
    tick();
    check_eq("rd_ack_c2", 32'(cpu_ack), 32'd1);
    check_eq("rd_rdata_c2", 32'(cpu_rdata), 32'h41);
    check_eq("rd_stall", 32'(stall_cnt), 32'h0);
    cpu_req = 1'b0;
    tick();
    check_eq("rd_ack_c3", 32'(cpu_ack), 32'd0);

    // Write 0x5A to 0x1234, then read it back
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
    #1;
    check_eq("wr_ram_we_c0", 32'(ram_we), 32'd1);
    check_eq("wr_ram_wdata_c0", 32'(ram_wdata), 32'h5A);
    tick(); tick();
    check_eq("wr_ack_c2", 32'(cpu_ack), 32'd1);
    check_eq("wr_rdata_kept", 32'(cpu_rdata), 32'h41);
    cpu_we = 1'b0;
    tick();
    check_eq("rb_grant_c3", 32'(ram_en), 32'd1);
    check_eq("rb_ram_we_c3", 32'(ram_we), 32'd0);
    check_eq("rb_ram_addr_c3", 32'(ram_addr), 32'h1234);
    tick();
    check_eq("rb_ack_c4", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("rb_ack_c5", 32'(cpu_ack), 32'd1);
    check_eq("rb_rdata_c5", 32'(cpu_rdata), 32'h5A);
    cpu_req = 1'b0;
    tick();

    // Collision: video fetch of 0xF600 together with CPU read of 0x0010
    mem[16'hF600] = 8'h20;
    tick();
    vid_en = 1'b1; vid_addr = 16'hF600;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    check_eq("col_ram_addr_c0", 32'(ram_addr), 32'hF600);
    check_eq("col_ram_we_c0", 32'(ram_we), 32'd0);
    tick();
    vid_en = 1'b0;
    #1;
    check_eq("col_vid_data_c1", 32'(vid_data), 32'h20);
    check_eq("col_grant_addr_c1", 32'(ram_addr), 32'h0010);
    check_eq("col_stall_c1", 32'(stall_cnt), 32'd1);
    tick();
    check_eq("col_ack_c2", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("col_ack_c3", 32'(cpu_ack), 32'd1);
    check_eq("col_rdata_c3", 32'(cpu_rdata), 32'h99);
    check_eq("col_vid_hold_c3", 32'(vid_data), 32'h20);
    cpu_req = 1'b0;
    tick();

    // Video every 8th cycle for 1000 cycles, CPU read of 0x0020 held high
    exp_hold = 8'h20; prev_vid = 1'b0; prev_data = 8'h00; acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    for (int i = 0; i < 1000; i++) begin
      tick();
      vid_en   = (i % 8 == 0);
      vid_addr = 16'h8000 + 16'(i);
      #1;
      if (prev_vid) begin
        exp_hold = prev_data;
        check_eq("loop_vid_data", 32'(vid_data), 32'(prev_data));
      end else begin
        check_eq("loop_vid_held", 32'(vid_data), 32'(exp_hold));
      end
      if (vid_en) begin
        check_eq("loop_vid_ram_addr", 32'(ram_addr), 32'(vid_addr));
        check_eq("loop_vid_ram_we", 32'(ram_we), 32'd0);
      end
      if (cpu_ack) begin
        acks++;
        check_eq("loop_cpu_rdata", 32'(cpu_rdata), 32'h77);
      end
      prev_vid  = vid_en;
      prev_data = 8'(i * 7 + 3);
    end
    check_eq("loop_acks_seen", 32'(acks > 200), 32'd1);
    vid_en = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick(); tick();

    // Reset while the access is in RESP
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    tick();
    clk_locked = 1'b0; cpu_req = 1'b0;
    #1;
    check_eq("rr_ack", 32'(cpu_ack), 32'd0);
    check_eq("rr_rdata", 32'(cpu_rdata), 32'h0);
    check_eq("rr_vid_data", 32'(vid_data), 32'h0);
    check_eq("rr_stall", 32'(stall_cnt), 32'h0);
    check_eq("rr_ram_en", 32'(ram_en), 32'd0);
    tick();
    check_eq("rr_ack_held", 32'(cpu_ack), 32'd0);
    #2 clk_locked = 1'b1;
    tick();
    check_eq("rr_no_late_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1;
    #1;
    check_eq("rr_fresh_grant", 32'(ram_en), 32'd1);
    tick(); tick();
    check_eq("rr_fresh_ack", 32'(cpu_ack), 32'd1);
    check_eq("rr_fresh_rdata", 32'(cpu_rdata), 32'h99);
    cpu_req = 1'b0;
    tick();

    // Saturation of a 2-bit stall counter over 5 deferred cycles
    check_eq("sat_start", 32'(stall_cnt2), 32'd0);
    vid_en2 = 1'b1; cpu_req2 = 1'b1;
    tick(); tick();
    check_eq("sat_after2", 32'(stall_cnt2), 32'd2);
    tick(); tick(); tick();
    check_eq("sat_after5", 32'(stall_cnt2), 32'd3);
    vid_en2 = 1'b0;
    tick();
    check_eq("sat_hold", 32'(stall_cnt2), 32'd3);
    cpu_req2 = 1'b0;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous video RAM between the character-fetch path of the video controller and a CPU request port. Video fetches get absolute, zero-wait priority so the text display never loses a character. CPU accesses use a req/ack handshake and fill the idle slots. The block sits between the video controller's `addr`/`en`/`din` port, the CPU bus, and the RAM macro.

## Interface
- `ADDR_WIDTH`, 16, RAM address width
- `DATA_WIDTH`, 8, RAM data width
- `STALL_WIDTH`, 8, width of the saturating CPU stall counter

- `clk_pixel` in 1: pixel clock; the only clock
- `clk_locked` in 1: reset, asynchronous, active-low (0 = reset)
- `vid_addr` in ADDR_WIDTH: video fetch address
- `vid_en` in 1: video fetch strobe, one cycle per access
- `vid_data` out DATA_WIDTH: video read data, valid in the cycle after `vid_en`
- `cpu_req` in 1: CPU request; held with addr/we/wdata until ack
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_WIDTH: CPU address
- `cpu_wdata` in DATA_WIDTH: CPU write data
- `cpu_rdata` out DATA_WIDTH: CPU read data, valid while `cpu_ack`=1
- `cpu_ack` out 1: one-cycle completion pulse
- `stall_cnt` out STALL_WIDTH: saturating count of CPU cycles deferred by video
- `ram_addr` out ADDR_WIDTH: RAM address
- `ram_en` out 1: RAM access enable
- `ram_we` out 1: RAM write enable
- `ram_wdata` out DATA_WIDTH: RAM write data
- `ram_rdata` in DATA_WIDTH: RAM read data, one cycle after the enabled access edge

## Operation
- CPU FSM has three states:
  - IDLE: waiting for a request.
  - RESP: the RAM access is in flight.
  - ACK: `cpu_ack`=1.
- Grant is combinational: `cpu_grant = (state==IDLE) && cpu_req && !vid_en`.
- RAM port mux is combinational:
  - When `vid_en` is high: `ram_addr=vid_addr`, `ram_en=1`, `ram_we=0`.
  - Else when `cpu_grant` is high: `ram_addr=cpu_addr`, `ram_en=1`, `ram_we=cpu_we`, `ram_wdata=cpu_wdata`.
  - Otherwise `ram_en=0` and `ram_we=0`. `ram_addr` and `ram_wdata` are don't-care but must be driven, not X.
- FSM transitions:
  - IDLE→RESP on `cpu_grant`.
  - RESP→ACK unconditionally. On this edge, `cpu_rdata<=ram_rdata` for reads; `cpu_rdata` is unchanged for writes.
  - ACK→IDLE unconditionally.
- `cpu_ack` is registered and equals (state==ACK).
- Each ack consumes exactly one request. If `cpu_req` is still high in IDLE after an ack, it is a new access.
- Video path:
  - Register `vid_prev<=vid_en`.
  - `vid_data = vid_prev ? ram_rdata : vid_hold`.
  - `vid_hold<=ram_rdata` when `vid_prev`=1.
  - `vid_data` is stable between fetches.
- `vid_en` during RESP or ACK does not conflict. The RAM is pipelined, so the video result lands one cycle after the CPU result.
- `stall_cnt` increments when state==IDLE && `cpu_req` && `vid_en`. It saturates at all-ones and clears only on reset.
- A CPU write is committed at the grant edge. Read data is never forwarded from a pending write; a read issued after a write's ack returns the new value.

## Timing
- Reset (`clk_locked`=0, asynchronous) sets:
  - state to IDLE
  - `cpu_ack`=0, `cpu_rdata`=0
  - `vid_prev`=0, `vid_hold`=0, so `vid_data`=0
  - `stall_cnt`=0
- Video latency: `vid_en` high in cycle N → `vid_data` valid in cycle N+1. The video path never waits, in any state.
- CPU latency with no contention: req seen in cycle N (IDLE) → RAM access at edge N/N+1 → `cpu_ack`=1 in cycle N+2.
  - Minimum spacing between back-to-back acks is 3 cycles.
- Contention: `vid_en` in the cycle req is first seen delays the grant by exactly 1 cycle per `vid_en` cycle. `stall_cnt` increments once per deferred cycle.
- Reset mid-operation aborts the FSM; no ack is issued. A write already granted remains in RAM. The CPU must reissue.
- `cpu_req` dropping during RESP is a protocol violation; the access still completes and acks.

## Test plan
- **Single read:** RAM[0xF600]=0x41, `cpu_req` read 0xF600 in cycle 0 with no video → `ram_en`=1 in cycle 0, `cpu_ack`=1 with `cpu_rdata`=0x41 in cycle 2, `stall_cnt`=0.
- **Write then read:** write 0x5A to 0x1234, then read 0x1234 → first ack in cycle 2, second req granted in cycle 3, ack in cycle 5 with `cpu_rdata`=0x5A.
- **Collision:** `vid_en`=1 with `vid_addr`=0xF600 (holding 0x20) in the same cycle as a CPU read of 0x0010 (holding 0x99):
  - `ram_addr`=0xF600 that cycle; `vid_data`=0x20 in the next cycle.
  - CPU granted 1 cycle late; ack in cycle 3 with 0x99; `stall_cnt`=1.
- **Video every 8th cycle for 1000 cycles, CPU req held high:** every `vid_en` is followed by correct `vid_data`; no `ram_en` on `vid_en` cycles goes to the CPU; `vid_data` is held between fetches.
- **Saturation:** with `STALL_WIDTH`=2 and 5 deferred cycles → `stall_cnt` stops at 3.
- **Reset in RESP:** assert `clk_locked`=0 in the cycle after grant → `cpu_ack` stays 0, all outputs at reset values; after release, a fresh read completes in 3 cycles.
